conv_layer_stream: RTL
======================

CONV_LAYER_STREAM -- requirements
Module: conv_layer_stream

Interface
REQ-001 Parameter BITWIDTH, default 8, signed width of pixels, coefficients and outputs.
REQ-002 Parameter IMG_W, default 32, input frame width in pixels.
REQ-003 Parameter IMG_H, default 32, input frame height in pixels.
REQ-004 Parameter KSIZE, default 5, square kernel side.
REQ-005 Parameter NUM_K, default 2, number of kernels (output channels), all computed in parallel.
REQ-006 Parameter SHIFT, default 0, arithmetic right shift applied to each sum before saturation.
REQ-007 Port clk, input, 1, single clock; every register is updated on its rising edge.
REQ-008 Port rst, input, 1, synchronous active-high reset.
REQ-009 Port start, input, 1, single-cycle pulse that begins a frame; honoured only in IDLE.
REQ-010 Port k_wr_en, input, 1, coefficient write strobe; honoured only in IDLE.
REQ-011 Port k_wr_addr, input, clog2(NUM_K*KSIZE*KSIZE), coefficient index: kernel*KSIZE*KSIZE + row*KSIZE + col.
REQ-012 Port k_wr_data, input, BITWIDTH, signed coefficient value.
REQ-013 Port in_valid / in_data, input, 1 / BITWIDTH, raster-order pixel stream, row 0 first.
REQ-014 Port in_ready, output, 1, pixel accepted when in_valid and in_ready are both high.
REQ-015 Port out_valid / out_ready, output / input, 1 / 1, output handshake.
REQ-016 Port out_data, output, NUM_K*BITWIDTH, channel n in bits [n*BITWIDTH +: BITWIDTH].
REQ-017 Port out_last, output, 1, high with the final output beat of a frame.
REQ-018 Port busy / done, output, 1 / 1, busy high outside IDLE; done is a one-cycle pulse at frame end.

Function
REQ-019 The FSM SHALL have three states: IDLE -> RUN on start; RUN -> DONE when the out_last beat handshakes; DONE -> IDLE after one cycle, with done high during that DONE cycle.
REQ-020 in_ready SHALL be high only in RUN, only until IMG_W*IMG_H pixels have been accepted, and only while (!out_valid || out_ready).
REQ-021 Each accepted pixel SHALL be written to a (KSIZE-1)-row line buffer and a KSIZE x KSIZE window register, with column and row counters wrapping at IMG_W and IMG_H.
REQ-022 An output SHALL be produced for each accepted pixel at row >= KSIZE-1 and col >= KSIZE-1, giving (IMG_H-KSIZE+1)*(IMG_W-KSIZE+1) beats per frame (784 at the defaults).
REQ-023 Output (i,j), channel n, SHALL equal sat(( sum over r,c of pixel[i+r][j+c]*coef[n][r][c] ) >>> SHIFT), a valid cross-correlation with no padding.
REQ-024 Products and sums SHALL be exact at 2*BITWIDTH+clog2(KSIZE*KSIZE) bits; sat() SHALL clamp to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
REQ-025 Latency SHALL be 1 cycle: out_valid rises on the clock edge that accepts the completing pixel.
REQ-026 out_data, out_valid and out_last SHALL hold steady while out_valid=1 and out_ready=0.
REQ-027 out_last SHALL be high only on the beat for output (IMG_H-KSIZE, IMG_W-KSIZE).
REQ-028 start, or k_wr_en, asserted outside IDLE SHALL be ignored, with no effect on coefficients or counters.
REQ-029 Coefficients SHALL persist across frames and across rst.

Reset
REQ-030 While rst is high, the block SHALL enter IDLE and drive in_ready, out_valid, out_last, busy and done to 0 and out_data to 0.
REQ-031 rst SHALL clear the counters and the window registers; line-buffer contents need not be cleared.
REQ-032 rst asserted mid-frame SHALL discard the partial frame; the next start SHALL process a fresh frame correctly.

Structure
REQ-033 A shared package conv_pkg SHALL hold the accumulator-width function, the sat() function and the FSM state enum.
REQ-034 Per-channel MAC-and-saturate logic SHALL be one sub-module, conv_window_mac, instantiated NUM_K times.

Verification (defaults; SHIFT=0 unless stated)
REQ-035 Reset: drive rst for 2 cycles -> all outputs 0, busy 0, in_ready 0.
REQ-036 Identity kernel: coef[n][2][2]=1, all others 0; pixel(r,c)=(r+c)%64 -> 784 beats with out(i,j)=(i+j+4)%64 on both channels; out_last on beat 784; done one cycle later.
REQ-037 Saturation: all pixels 127 with all coefs 127 -> 127; with all coefs -128 -> -128; with SHIFT=7, all pixels 1 and coef 128-lot... -> set all coefs 4, pixels 32 -> (25*128)>>>7 = 25.
REQ-038 Backpressure: out_ready random at 50%, in_valid random at 70% -> identical 784-beat sequence to the unstalled run, no drops or duplicates, out_data stable while stalled.
REQ-039 Mid-frame reset: rst after 100 pixels accepted -> IDLE with outputs 0; a following identity frame matches REQ-036 exactly.
REQ-040 Ignored writes: k_wr_en with data 99 during RUN -> that frame's and the next frame's outputs are unchanged.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the streaming convolution layer.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SAT_W = 64;

  // Width that holds any KSIZE*KSIZE sum of BITWIDTH x BITWIDTH products exactly.
  function automatic int acc_width(input int bw, input int ksize);
    return 2 * bw + $clog2(ksize * ksize);
  endfunction

  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] value,
                                                   input int bw);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = 1;
    hi  = (one <<< (bw - 1)) - one;
    lo  = -(one <<< (bw - 1));
    if (value > hi) return hi;
    else if (value < lo) return lo;
    else return value;
  endfunction

endpackage

// File: rtl/conv_window_mac.sv
// One output channel: exact multiply-accumulate over a KSIZE x KSIZE window, shift, saturate.
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int KSIZE    = 5,
  parameter int SHIFT    = 0
) (
  input  logic [KSIZE*KSIZE*BITWIDTH-1:0] window,
  input  logic [KSIZE*KSIZE*BITWIDTH-1:0] coef,
  output logic [BITWIDTH-1:0]             result
);

  localparam int ACC_W = acc_width(BITWIDTH, KSIZE);
  localparam int TAPS  = KSIZE * KSIZE;

  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] pix_ext;
  logic signed [ACC_W-1:0] coef_ext;

  always_comb begin
    sum      = '0;
    pix_ext  = '0;
    coef_ext = '0;
    for (int t = 0; t < TAPS; t++) begin
      pix_ext  = ACC_W'(signed'(window[t*BITWIDTH +: BITWIDTH]));
      coef_ext = ACC_W'(signed'(coef[t*BITWIDTH +: BITWIDTH]));
      sum      = sum + pix_ext * coef_ext;
    end
    shifted = sum >>> SHIFT;
    result  = BITWIDTH'(sat(SAT_W'(shifted), BITWIDTH));
  end

endmodule

// File: rtl/conv_layer_stream.sv
// Streaming valid (no padding) 2-D cross-correlation of a raster pixel stream with NUM_K kernels.
module conv_layer_stream
  import conv_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int KSIZE    = 5,
  parameter int NUM_K    = 2,
  parameter int SHIFT    = 0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic                                     k_wr_en,
  input  logic [$clog2(NUM_K*KSIZE*KSIZE)-1:0]     k_wr_addr,
  input  logic [BITWIDTH-1:0]                      k_wr_data,
  input  logic                                     in_valid,
  input  logic [BITWIDTH-1:0]                      in_data,
  output logic                                     in_ready,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [NUM_K*BITWIDTH-1:0]                out_data,
  output logic                                     out_last,
  output logic                                     busy,
  output logic                                     done,
  output state_t                                   fsm_state
);

  localparam int TAPS  = KSIZE * KSIZE;
  localparam int NCOEF = NUM_K * TAPS;
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW    = $clog2(TOTAL + 1);

  // Handshake rule for both streams: a beat moves on a rising edge where valid and ready
  // are both high; valid never waits on ready, and a held output beat is frozen until taken.

  state_t state, state_next;

  logic [BITWIDTH-1:0] coef_mem [NCOEF];
  logic [BITWIDTH-1:0] line_buf [KSIZE-1][IMG_W];
  logic [BITWIDTH-1:0] win      [KSIZE][KSIZE];
  logic [BITWIDTH-1:0] win_next [KSIZE][KSIZE];
  logic [BITWIDTH-1:0] col_vec  [KSIZE];

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [PW-1:0] pix_cnt;

  logic [TAPS*BITWIDTH-1:0] win_flat;
  logic [TAPS*BITWIDTH-1:0] coef_flat [NUM_K];
  logic [BITWIDTH-1:0]      mac_res   [NUM_K];
  logic [NUM_K*BITWIDTH-1:0] mac_flat;

  logic accept;
  logic emit;
  logic last_pix;
  logic all_in;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (out_valid && out_ready && out_last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign fsm_state = state;

  assign all_in   = (pix_cnt == PW'(TOTAL));
  assign in_ready = (state == ST_RUN) && !all_in && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign emit     = (row_cnt >= RW'(KSIZE - 1)) && (col_cnt >= CW'(KSIZE - 1));
  assign last_pix = (row_cnt == RW'(IMG_H - 1)) && (col_cnt == CW'(IMG_W - 1));

  // Coefficients have no reset so they survive rst and are reused frame to frame.
  always_ff @(posedge clk) begin
    if (k_wr_en && state == ST_IDLE && 32'(k_wr_addr) < NCOEF)
      coef_mem[k_wr_addr] <= k_wr_data;
  end

  always_comb begin
    for (int n = 0; n < NUM_K; n++) begin
      coef_flat[n] = '0;
      for (int t = 0; t < TAPS; t++)
        coef_flat[n][t*BITWIDTH +: BITWIDTH] = coef_mem[n*TAPS + t];
    end
  end

  // New window column: buffered rows (oldest at index 0) above the incoming pixel.
  always_comb begin
    win_flat = '0;
    for (int r = 0; r < KSIZE - 1; r++)
      col_vec[r] = line_buf[r][col_cnt];
    col_vec[KSIZE-1] = in_data;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        win_next[r][c] = (c < KSIZE - 1) ? win[r][c+1] : col_vec[r];
        win_flat[(r*KSIZE + c)*BITWIDTH +: BITWIDTH] = win_next[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < KSIZE - 2; r++)
        line_buf[r][col_cnt] <= line_buf[r+1][col_cnt];
      line_buf[KSIZE-2][col_cnt] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
      pix_cnt <= '0;
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE; c++)
          win[r][c] <= '0;
    end else if (state == ST_IDLE && start) begin
      col_cnt <= '0;
      row_cnt <= '0;
      pix_cnt <= '0;
    end else if (accept) begin
      win     <= win_next;
      pix_cnt <= pix_cnt + 1'b1;
      if (col_cnt == CW'(IMG_W - 1)) begin
        col_cnt <= '0;
        row_cnt <= (row_cnt == RW'(IMG_H - 1)) ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  for (genvar n = 0; n < NUM_K; n++) begin : g_mac
    conv_window_mac #(
      .BITWIDTH(BITWIDTH),
      .KSIZE   (KSIZE),
      .SHIFT   (SHIFT)
    ) u_mac (
      .window(win_flat),
      .coef  (coef_flat[n]),
      .result(mac_res[n])
    );
  end

  always_comb begin
    mac_flat = '0;
    for (int n = 0; n < NUM_K; n++)
      mac_flat[n*BITWIDTH +: BITWIDTH] = mac_res[n];
  end

  // Result is registered on the accepting edge, giving one cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (accept && emit) begin
      out_valid <= 1'b1;
      out_last  <= last_pix;
      out_data  <= mac_flat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
